// File: rtl/sort_pkg.sv
// Purpose : shared ALU/decoder codes and FSM state encoding for the sort sequencer.
// Latency : n/a (constants and a width helper only).
// Backpr. : n/a.
package sort_pkg;

    // ALU operation codes understood by the existing datapath ALU
    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    // Write-decoder code that suppresses the register-file write
    localparam logic [3:0] DECO_NOWRITE = 4'b1000;

    // Sequencer states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMP  = 3'd1;
    localparam logic [2:0] ST_SWP0 = 3'd2;
    localparam logic [2:0] ST_SWP1 = 3'd3;
    localparam logic [2:0] ST_SWP2 = 3'd4;
    localparam logic [2:0] ST_PASS = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    // Loop-counter width: enough to index NREG elements, never zero bits
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sort_loop_counter.sv
// Purpose : pass index i, compare index j and the per-pass swapped flag of the bubble sort.
// Latency : controls take effect on the next clk edge; flags are combinational from state.
// Backpr. : none; the FSM drives the controls every cycle.
// Ports   : clk/highRst; clr_all_i, inc_j_i, next_pass_i, set_swapped_i controls;
//           j_o index, swapped_o flag, last_cmp_o (j == NREG-2-i), last_pass_o (i == NREG-2).
module sort_loop_counter
    import sort_pkg::*;
#(
    parameter int NREG = 5,
    parameter int CW   = cnt_width(NREG)
) (
    input  logic          clk,
    input  logic          highRst,
    input  logic          clr_all_i,
    input  logic          inc_j_i,
    input  logic          next_pass_i,
    input  logic          set_swapped_i,
    output logic [CW-1:0] j_o,
    output logic          swapped_o,
    output logic          last_cmp_o,
    output logic          last_pass_o
);

    // One extra bit so i+j and NREG-2 cannot wrap
    localparam int LW = CW + 1;
    localparam logic [LW-1:0] LAST = LW'(NREG - 2);

    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic          swapped_q, swapped_d;

    always_ff @(posedge clk) begin
        if (highRst) begin
            i_q       <= '0;
            j_q       <= '0;
            swapped_q <= 1'b0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            swapped_q <= swapped_d;
        end
    end

    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        swapped_d = swapped_q;
        if (clr_all_i) begin
            i_d       = '0;
            j_d       = '0;
            swapped_d = 1'b0;
        end else if (next_pass_i) begin
            i_d       = i_q + CW'(1);
            j_d       = '0;
            swapped_d = 1'b0;
        end else begin
            if (inc_j_i) begin
                j_d = j_q + CW'(1);
            end
            if (set_swapped_i) begin
                swapped_d = 1'b1;
            end
        end
    end

    // j == NREG-2-i rewritten as i+j == NREG-2 so no subtraction can underflow
    assign last_cmp_o  = (({1'b0, i_q} + {1'b0, j_q}) == LAST);
    assign last_pass_o = ({1'b0, i_q} == LAST);
    assign j_o         = j_q;
    assign swapped_o   = swapped_q;

endmodule

// File: rtl/sort_sequencer.sv
// Purpose : bubble-sort sequencer driving register-file/ALU selects to sort NREG regs in place.
// Latency : compares + 3*swaps + passes + 1 cycles from the start edge to the sDone cycle.
// Backpr. : none; sStart is ignored while busy, Moore outputs decoded from registered state.
// Ports   : clk, highRst (sync, active-high), sStart, sNegative/sZero ALU flags in;
//           sSelDecoA/B read codes, sSelDecoC write code, sSelAlu, sBusy, sDone out.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int NREG          = 5,
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 4,
    parameter int BASE          = 0,
    parameter int TMP           = 5
) (
    input  logic                     clk,
    input  logic                     highRst,
    input  logic                     sStart,
    input  logic                     sNegative,
    input  logic                     sZero,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sBusy,
    output logic                     sDone
);

    localparam int CW = cnt_width(NREG);
    localparam logic [SELECTIONDECO-1:0] NOWR    = SELECTIONDECO'(DECO_NOWRITE);
    localparam logic [SELECTIONDECO-1:0] TMP_SEL = SELECTIONDECO'(TMP);
    localparam logic [SELECTIONDECO-1:0] BASE_SEL = SELECTIONDECO'(BASE);

    logic [2:0]    state_q, state_d;
    logic          clr_all, inc_j, next_pass, set_swapped;
    logic [CW-1:0] j;
    logic          swapped, last_cmp, last_pass;
    logic          greater;

    logic [SELECTIONDECO-1:0] sel_j, sel_j1;

    sort_loop_counter #(
        .NREG (NREG),
        .CW   (CW)
    ) u_cnt (
        .clk           (clk),
        .highRst       (highRst),
        .clr_all_i     (clr_all),
        .inc_j_i       (inc_j),
        .next_pass_i   (next_pass),
        .set_swapped_i (set_swapped),
        .j_o           (j),
        .swapped_o     (swapped),
        .last_cmp_o    (last_cmp),
        .last_pass_o   (last_pass)
    );

    // R[j] - R[j+1] > 0 ; equal values fall through, which keeps the sort stable
    assign greater = !sNegative && !sZero;

    assign sel_j  = BASE_SEL + SELECTIONDECO'(j);
    assign sel_j1 = sel_j + SELECTIONDECO'(1);

    always_ff @(posedge clk) begin
        if (highRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_all     = 1'b0;
        inc_j       = 1'b0;
        next_pass   = 1'b0;
        set_swapped = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sStart) begin
                    if (NREG <= 1) begin
                        state_d = ST_DONE;
                    end else begin
                        clr_all = 1'b1;
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                if (greater) begin
                    state_d = ST_SWP0;
                end else if (!last_cmp) begin
                    inc_j = 1'b1;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_SWP0: state_d = ST_SWP1;
            ST_SWP1: state_d = ST_SWP2;
            ST_SWP2: begin
                set_swapped = 1'b1;
                if (!last_cmp) begin
                    inc_j   = 1'b1;
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                // No swap in this pass means the array is already ordered
                if (!swapped || last_pass) begin
                    state_d = ST_DONE;
                end else begin
                    next_pass = 1'b1;
                    state_d   = ST_CMP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        sSelDecoA = '0;
        sSelDecoB = '0;
        sSelDecoC = NOWR;
        sSelAlu   = SELECTIONALU'(ALU_PASSA);
        sBusy     = (state_q != ST_IDLE);
        sDone     = 1'b0;
        case (state_q)
            ST_CMP: begin
                sSelDecoA = sel_j;
                sSelDecoB = sel_j1;
                sSelAlu   = SELECTIONALU'(ALU_SUB);
            end
            ST_SWP0: begin
                sSelDecoA = sel_j;
                sSelDecoC = TMP_SEL;
            end
            ST_SWP1: begin
                sSelDecoB = sel_j1;
                sSelAlu   = SELECTIONALU'(ALU_PASSB);
                sSelDecoC = sel_j;
            end
            ST_SWP2: begin
                sSelDecoA = TMP_SEL;
                sSelDecoC = sel_j1;
            end
            ST_DONE: sDone = 1'b1;
            default: ;
        endcase
    end

endmodule
